// File: rtl/dispatch_queue.sv
// In-order dispatch buffer: holds decoded instructions, captures operands from the
// write-back bus, issues the head to its unit. Optional counters: DISPATCH_QUEUE_STATS_EN.
module dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int NUM_UNITS = 9,
  parameter int UNIT_W    = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [UNIT_W-1:0]          enq_unit,
  input  logic [3*TAG_W-1:0]         enq_src_tag,
  input  logic [2:0]                 enq_src_rdy,
  input  logic [3*XLEN-1:0]          enq_src_val,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_tag,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  output logic                       iss_valid,
  output logic [NUM_UNITS-1:0]       iss_unit_en,
  output logic [3*XLEN-1:0]          iss_src_val,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH):0]     count
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                stall_operand_cnt,
  output logic [31:0]                stall_unit_cnt,
  output logic [31:0]                full_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                 r_valid   [DEPTH];
  logic [UNIT_W-1:0]    r_unit    [DEPTH];
  logic [TAG_W-1:0]     r_tag     [DEPTH][3];
  logic [2:0]           r_rdy     [DEPTH];
  logic [XLEN-1:0]      r_val     [DEPTH][3];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 w_head_eligible;
  logic                 w_unit_ok;
  logic [NUM_UNITS-1:0] w_unit_en;
  logic                 w_enq_fire;
  logic                 w_iss_fire;

  always_comb begin
    w_head_eligible = r_valid[r_head] && (&r_rdy[r_head]);
    w_unit_en       = '0;
    // Codes outside 1..NUM_UNITS are nops: never blocked, no enable.
    w_unit_ok       = 1'b1;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      if (r_unit[r_head] == UNIT_W'(k + 1)) begin
        w_unit_en[k] = 1'b1;
        w_unit_ok    = unit_ready[k];
      end
    end
    iss_valid   = w_head_eligible && w_unit_ok;
    iss_unit_en = iss_valid ? w_unit_en : '0;
    enq_ready   = rstn && (r_count != FULL_CNT) && !flush;
    for (int unsigned i = 0; i < 3; i++) begin
      iss_src_val[i*XLEN +: XLEN] = r_val[r_head][i];
    end
    iss_payload = r_payload[r_head];
    count       = r_count;
    w_enq_fire  = enq_valid && enq_ready;
    w_iss_fire  = iss_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        r_valid[d]   <= 1'b0;
        r_unit[d]    <= '0;
        r_rdy[d]     <= '0;
        r_payload[d] <= '0;
        for (int unsigned i = 0; i < 3; i++) begin
          r_tag[d][i] <= '0;
          r_val[d][i] <= '0;
        end
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        r_valid[d] <= 1'b0;
      end
    end else begin
      for (int unsigned d = 0; d < DEPTH; d++) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (r_valid[d] && !r_rdy[d][i] && wb_valid && (r_tag[d][i] == wb_tag)) begin
            r_val[d][i] <= wb_data;
            r_rdy[d][i] <= 1'b1;
          end
        end
      end
      if (w_iss_fire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      // The tail slot is never valid here, so this cannot collide with the snoop above.
      if (w_enq_fire) begin
        r_valid[r_tail]   <= 1'b1;
        r_unit[r_tail]    <= enq_unit;
        r_payload[r_tail] <= enq_payload;
        for (int unsigned i = 0; i < 3; i++) begin
          r_tag[r_tail][i] <= enq_src_tag[i*TAG_W +: TAG_W];
          if (!enq_src_rdy[i] && wb_valid && (enq_src_tag[i*TAG_W +: TAG_W] == wb_tag)) begin
            r_val[r_tail][i] <= wb_data;
            r_rdy[r_tail][i] <= 1'b1;
          end else begin
            r_val[r_tail][i] <= enq_src_val[i*XLEN +: XLEN];
            r_rdy[r_tail][i] <= enq_src_rdy[i];
          end
        end
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_enq_fire && !w_iss_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enq_fire && w_iss_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] r_stall_op;
  logic [31:0] r_stall_unit;
  logic [31:0] r_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_op   <= '0;
      r_stall_unit <= '0;
      r_full       <= '0;
    end else begin
      if (r_valid[r_head] && !(&r_rdy[r_head]) && (r_stall_op != '1)) begin
        r_stall_op <= r_stall_op + 32'd1;
      end
      if (w_head_eligible && !w_unit_ok && (r_stall_unit != '1)) begin
        r_stall_unit <= r_stall_unit + 32'd1;
      end
      if ((r_count == FULL_CNT) && (r_full != '1)) begin
        r_full <= r_full + 32'd1;
      end
    end
  end

  assign stall_operand_cnt = r_stall_op;
  assign stall_unit_cnt    = r_stall_unit;
  assign full_cnt          = r_full;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_queue;

  localparam int DEPTH     = 4;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 6;
  localparam int NUM_UNITS = 9;
  localparam int UNIT_W    = 4;
  localparam int PAYLOAD_W = 64;

  logic                   clk;
  logic                   rstn;
  logic                   flush;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [UNIT_W-1:0]      enq_unit;
  logic [3*TAG_W-1:0]     enq_src_tag;
  logic [2:0]             enq_src_rdy;
  logic [3*XLEN-1:0]      enq_src_val;
  logic [PAYLOAD_W-1:0]   enq_payload;
  logic                   wb_valid;
  logic [TAG_W-1:0]       wb_tag;
  logic [XLEN-1:0]        wb_data;
  logic [NUM_UNITS-1:0]   unit_ready;
  logic                   iss_valid;
  logic [NUM_UNITS-1:0]   iss_unit_en;
  logic [3*XLEN-1:0]      iss_src_val;
  logic [PAYLOAD_W-1:0]   iss_payload;
  logic [$clog2(DEPTH):0] count;
`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] stall_operand_cnt;
  logic [31:0] stall_unit_cnt;
  logic [31:0] full_cnt;
`endif

  dispatch_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W),
    .NUM_UNITS(NUM_UNITS), .UNIT_W(UNIT_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_unit(enq_unit),
    .enq_src_tag(enq_src_tag), .enq_src_rdy(enq_src_rdy), .enq_src_val(enq_src_val),
    .enq_payload(enq_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .unit_ready(unit_ready),
    .iss_valid(iss_valid), .iss_unit_en(iss_unit_en), .iss_src_val(iss_src_val),
    .iss_payload(iss_payload), .count(count)
`ifdef DISPATCH_QUEUE_STATS_EN
    , .stall_operand_cnt(stall_operand_cnt), .stall_unit_cnt(stall_unit_cnt),
    .full_cnt(full_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [UNIT_W-1:0]          unit;
    logic [2:0][TAG_W-1:0]      tag;
    logic [2:0]                 rdy;
    logic [2:0][XLEN-1:0]       val;
    logic [PAYLOAD_W-1:0]       payload;
  } ent_t;

  ent_t        mq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_op, m_un, m_full;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic m_iss_valid();
    int u;
    if (mq.size() == 0) return 1'b0;
    if (!(&mq[0].rdy)) return 1'b0;
    u = int'(mq[0].unit);
    if (u == 0 || u > NUM_UNITS) return 1'b1;
    return unit_ready[u-1];
  endfunction

  function automatic logic [NUM_UNITS-1:0] m_unit_en();
    logic [NUM_UNITS-1:0] e;
    int u;
    e = '0;
    if (m_iss_valid()) begin
      u = int'(mq[0].unit);
      if (u >= 1 && u <= NUM_UNITS) e[u-1] = 1'b1;
    end
    return e;
  endfunction

  task automatic compare_all();
    chk("count", 128'(count), 128'(mq.size()));
    chk("enq_ready", 128'(enq_ready), 128'(rstn && (mq.size() < DEPTH) && !flush));
    chk("iss_valid", 128'(iss_valid), 128'(m_iss_valid()));
    chk("iss_unit_en", 128'(iss_unit_en), 128'(m_unit_en()));
    if (mq.size() > 0) begin
      for (int i = 0; i < 3; i++) begin
        if (mq[0].rdy[i]) chk("iss_src_val", 128'(iss_src_val[i*XLEN +: XLEN]), 128'(mq[0].val[i]));
      end
      chk("iss_payload", 128'(iss_payload), 128'(mq[0].payload));
    end
`ifdef DISPATCH_QUEUE_STATS_EN
    chk("stall_operand_cnt", 128'(stall_operand_cnt), 128'(m_op));
    chk("stall_unit_cnt", 128'(stall_unit_cnt), 128'(m_un));
    chk("full_cnt", 128'(full_cnt), 128'(m_full));
`endif
  endtask

  task automatic model_edge();
    logic iv;
    logic room;
    int   u;
    ent_t e;
    if (!rstn) begin
      mq.delete();
      m_op = '0; m_un = '0; m_full = '0;
      return;
    end
    iv   = m_iss_valid();
    room = mq.size() < DEPTH;
    if (mq.size() > 0) begin
      u = int'(mq[0].unit);
      if (!(&mq[0].rdy) && m_op != '1) m_op++;
      if ((&mq[0].rdy) && u >= 1 && u <= NUM_UNITS && !unit_ready[u-1] && m_un != '1) m_un++;
    end
    if (mq.size() == DEPTH && m_full != '1) m_full++;
    if (flush) begin
      mq.delete();
      return;
    end
    if (iv) void'(mq.pop_front());
    for (int j = 0; j < mq.size(); j++) begin
      e = mq[j];
      for (int i = 0; i < 3; i++) begin
        if (!e.rdy[i] && wb_valid && e.tag[i] == wb_tag) begin
          e.val[i] = wb_data;
          e.rdy[i] = 1'b1;
        end
      end
      mq[j] = e;
    end
    if (enq_valid && room) begin
      e.unit    = enq_unit;
      e.tag     = enq_src_tag;
      e.rdy     = enq_src_rdy;
      e.payload = enq_payload;
      for (int i = 0; i < 3; i++) begin
        e.val[i] = enq_src_val[i*XLEN +: XLEN];
        if (!e.rdy[i] && wb_valid && e.tag[i] == wb_tag) begin
          e.val[i] = wb_data;
          e.rdy[i] = 1'b1;
        end
      end
      mq.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    enq_valid   = 1'b0;
    enq_unit    = '0;
    enq_src_tag = '0;
    enq_src_rdy = 3'b111;
    enq_src_val = '0;
    enq_payload = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    wb_data     = '0;
  endtask

  task automatic set_enq(input logic [UNIT_W-1:0] u, input logic [2:0] rdy,
                         input logic [3*TAG_W-1:0] tags, input logic [3*XLEN-1:0] vals,
                         input logic [PAYLOAD_W-1:0] pl);
    enq_valid   = 1'b1;
    enq_unit    = u;
    enq_src_rdy = rdy;
    enq_src_tag = tags;
    enq_src_val = vals;
    enq_payload = pl;
  endtask

  initial begin
    m_op = '0; m_un = '0; m_full = '0;
    rstn = 1'b0;
    unit_ready = '1;
    idle();
    step();
    step();
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_iss_valid", 128'(iss_valid), 128'(0));
    chk("rst_enq_ready", 128'(enq_ready), 128'(0));
    rstn = 1'b1;
    step();

    // Single ready instruction issues the following cycle.
    set_enq(4'd1, 3'b111, '0, {64'h0, 32'h0000_0005}, 64'h11);
    step();
    idle(); #1;
    chk("t1_iss_valid", 128'(iss_valid), 128'(1));
    chk("t1_unit_en", 128'(iss_unit_en), 128'(9'b000000001));
    chk("t1_src0", 128'(iss_src_val[31:0]), 128'(32'h5));
    step(); #1;
    chk("t1_count", 128'(count), 128'(0));

    // Operand waits for write-back, issues the cycle after capture.
    set_enq(4'd3, 3'b101, {6'h00, 6'h0A, 6'h00}, '0, 64'h22);
    step();
    idle(); #1;
    chk("t2_wait", 128'(iss_valid), 128'(0));
    step();
    wb_valid = 1'b1; wb_tag = 6'h0A; wb_data = 32'hDEAD_BEEF; #1;
    chk("t2_no_bypass", 128'(iss_valid), 128'(0));
    step();
    idle(); #1;
    chk("t2_iss_valid", 128'(iss_valid), 128'(1));
    chk("t2_src1", 128'(iss_src_val[63:32]), 128'(32'hDEAD_BEEF));
    chk("t2_unit_en", 128'(iss_unit_en), 128'(9'b000000100));
    step();

    // Fill with blocked unit, then drain in order and wrap.
    unit_ready = '0;
    for (int i = 0; i < 4; i++) begin
      set_enq(4'd2, 3'b111, '0, {3{32'(i)}}, 64'h300 + 64'(i));
      step();
    end
    idle(); #1;
    chk("t3_count_full", 128'(count), 128'(4));
    chk("t3_enq_ready_full", 128'(enq_ready), 128'(0));
    unit_ready = 9'b000000010;
    set_enq(4'd5, 3'b111, '0, '0, 64'h399); #1;
    chk("t3_no_passthru", 128'(enq_ready), 128'(0));
    chk("t3_unit_en", 128'(iss_unit_en), 128'(9'b000000010));
    chk("t3_order0", 128'(iss_payload), 128'(64'h300));
    step();
    idle();
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("t3_order", 128'(iss_payload), 128'(64'h300 + 64'(i)));
      step();
    end
    set_enq(4'd2, 3'b111, '0, '0, 64'h3AA);
    step();
    idle(); #1;
    chk("t3_wrap_count", 128'(count), 128'(1));
    chk("t3_wrap_payload", 128'(iss_payload), 128'(64'h3AA));
    step();

    // Capture on the enqueue cycle itself.
    unit_ready = '1;
    set_enq(4'd4, 3'b011, {6'h21, 6'h00, 6'h00}, '0, 64'h44);
    wb_valid = 1'b1; wb_tag = 6'h21; wb_data = 32'd7;
    step();
    idle(); #1;
    chk("t4_iss_valid", 128'(iss_valid), 128'(1));
    chk("t4_src2", 128'(iss_src_val[95:64]), 128'(32'd7));
    step();

    // Flush drops the simultaneous enqueue.
    unit_ready = '0;
    for (int i = 0; i < 3; i++) begin
      set_enq(4'd6, 3'b111, '0, '0, 64'h500 + 64'(i));
      step();
    end
    set_enq(4'd6, 3'b111, '0, '0, 64'h5FF);
    flush = 1'b1; #1;
    chk("t5_enq_ready_flush", 128'(enq_ready), 128'(0));
    step();
    idle(); #1;
    chk("t5_count", 128'(count), 128'(0));
    chk("t5_iss_valid", 128'(iss_valid), 128'(0));
    step();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 2; i++) begin
      set_enq(4'd7, 3'b111, '0, '0, 64'h600 + 64'(i));
      step();
    end
    idle(); #1;
    chk("t6_count_pre", 128'(count), 128'(2));
    rstn = 1'b0; #1;
    chk("t6_count_rst", 128'(count), 128'(0));
    chk("t6_iss_valid_rst", 128'(iss_valid), 128'(0));
    mq.delete();
    m_op = '0; m_un = '0; m_full = '0;
    step();
    rstn = 1'b1;
    step();

`ifdef DISPATCH_QUEUE_STATS_EN
    set_enq(4'd2, 3'b111, '0, '0, 64'h700);
    step();
    idle();
    repeat (10) step();
    #1;
    chk("t7_stall_unit_cnt", 128'(stall_unit_cnt), 128'(10));
    unit_ready = '1;
    step();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      enq_valid   = ($urandom_range(0, 3) != 0);
      enq_unit    = UNIT_W'($urandom_range(0, 11));
      for (int i = 0; i < 3; i++) begin
        enq_src_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
        enq_src_val[i*XLEN +: XLEN]   = $urandom;
      end
      enq_src_rdy = 3'($urandom);
      enq_payload = {$urandom, $urandom};
      wb_valid    = $urandom_range(0, 1) == 1;
      wb_tag      = TAG_W'($urandom_range(0, 7));
      wb_data     = $urandom;
      for (int k = 0; k < NUM_UNITS; k++) unit_ready[k] = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised in-order dispatch buffer between decode and the execution units; the next generation of the combinational dispatch stage.
- Holds up to DEPTH decoded instructions, each carrying up to three source operands.
- Snoops the write-back bus so a waiting operand captures its value when it arrives.
- Issues the oldest entry only when all its operands are ready and its target unit is ready, producing a one-hot unit enable.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
XLEN, 32, operand width
TAG_W, 6, source/dest register tag width ({fpu_bit, 5-bit index})
NUM_UNITS, 9, functional units; unit code k (1..NUM_UNITS) maps to enable bit k-1
UNIT_W, 4, width of unit code
PAYLOAD_W, 64, opaque control/immediate payload carried unchanged

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous: drop all entries
enq_valid  in  1  decode offers an instruction
enq_ready  out  1  queue accepts (count<DEPTH && !flush)
enq_unit  in  UNIT_W  target unit code; 0 = none (nop)
enq_src_tag  in  3*TAG_W  source tags, slot i at [i*TAG_W +: TAG_W]
enq_src_rdy  in  3  slot already holds valid data (unused slots driven 1)
enq_src_val  in  3*XLEN  source values (valid where rdy)
enq_payload  in  PAYLOAD_W  opaque payload
wb_valid  in  1  write-back bus valid
wb_tag  in  TAG_W  write-back destination tag
wb_data  in  XLEN  write-back value
unit_ready  in  NUM_UNITS  per-unit accept
iss_valid  out  1  head entry issuing this cycle
iss_unit_en  out  NUM_UNITS  one-hot enable of issuing unit; all zero for code 0
iss_src_val  out  3*XLEN  head operands
iss_payload  out  PAYLOAD_W  head payload
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rstn low, asynchronous): head = tail = 0, count = 0, all entry valid bits 0. iss_valid = 0, iss_unit_en = 0, enq_ready = 0 while in reset.
- Storage is a circular buffer. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is registered.
- Enqueue fires on enq_valid && enq_ready. It writes the entry at tail and increments tail.
- Same-cycle snoop on enqueue: if wb_valid and wb_tag equals a non-ready slot's tag, that slot stores wb_data with rdy = 1.
- Snoop on held entries, every cycle: every valid entry's non-ready slot whose tag == wb_tag with wb_valid captures wb_data and sets rdy. Multiple matches all capture.
- Slots whose rdy is already 1 are never overwritten.
- Head eligible when the entry is valid and all three slots are rdy.
- iss_valid = eligible && (unit == 0 || unit > NUM_UNITS || unit_ready[unit-1]). This is combinational from registered state and unit_ready.
- iss_unit_en = one-hot of unit-1 when iss_valid and 1 <= unit <= NUM_UNITS; else 0.
- Codes 0 and >NUM_UNITS issue as nop: dequeued with zero enable.
- On iss_valid the head is dequeued at the clock edge. Operands captured by write-back are visible at issue the cycle after capture. No bypass of wb_data directly to iss_src_val.
- Minimum latency is enqueue at edge t, issue at edge t+1. Throughput is 1 instruction/cycle.
- Full (count == DEPTH): enq_ready = 0, even if the head issues that cycle (no same-cycle pass-through).
- Empty: iss_valid = 0, and iss_* data outputs hold the last head entry contents (don't-care).
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- flush: on the next edge all valid bits clear, head = tail = 0, count = 0. Flush takes priority over enqueue, issue and snoop. iss_valid is still computed normally during the flush cycle; the consumer must ignore it.
- No ordering bypass: a ready younger entry never issues before the head.

Optional Feature:
- Macro DISPATCH_QUEUE_STATS_EN.
- When defined, three outputs are added:
  - stall_operand_cnt: 32-bit count of cycles where the head is valid but not all operands are rdy.
  - stall_unit_cnt: 32-bit count of cycles where the head is eligible but the unit is not ready.
  - full_cnt: 32-bit count of cycles where count == DEPTH.
- All three counters reset to 0, saturate at 32'hFFFF_FFFF and are unaffected by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Enqueue unit=1, all rdy, src0=32'h0000_0005, unit_ready=all 1 -> next cycle iss_valid=1, iss_unit_en=9'b000000001, iss_src_val slot0=5, count returns to 0.
- Enqueue unit=3 with slot1 tag=6'h0A rdy=0; two cycles later wb_valid, wb_tag=6'h0A, wb_data=32'hDEAD_BEEF -> iss_valid rises the cycle after write-back, slot1=32'hDEAD_BEEF, iss_unit_en=9'b000000100.
- unit_ready=0, enqueue 4 entries with unit=2 -> count=4, enq_ready=0. Raise unit_ready[1] -> one issue per cycle in enqueue order. Pointers wrap and a 5th enqueue succeeds.
- Enqueue with tag 6'h21 rdy=0 in the same cycle as wb_tag=6'h21, wb_data=7 -> entry captures 7, issues next cycle.
- Fill 3 entries then assert flush together with enq_valid -> enqueue dropped, count=0 next cycle, iss_valid=0.
- Deassert rstn mid-stream with count=2 -> count=0, iss_valid=0 immediately. With DISPATCH_QUEUE_STATS_EN, hold the head blocked on its unit 10 cycles -> stall_unit_cnt=10.
